mlp_run_sequencer: RTL and testbench

MLP_RUN_SEQUENCER -- requirements
Module: mlp_run_sequencer

---
 rtl/mlp_run_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mlp_run_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_run_sequencer.sv
// rtl/mlp_run_sequencer.sv - batch sequencer that starts N MLP runs and gathers accuracy statistics
// Optional watchdog on WAIT enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_run_sequencer #(
    parameter int ACC_W          = 10,
    parameter int RUN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [RUN_W-1:0]       num_runs,
    input  logic                   mlp_done,
    input  logic [ACC_W-1:0]       mlp_accuracy,
    output logic                   mlp_start,
    output logic                   busy,
    output logic                   all_done,
    output logic [RUN_W-1:0]       run_count,
    output logic [ACC_W-1:0]       last_acc,
    output logic [ACC_W-1:0]       min_acc,
    output logic [ACC_W-1:0]       max_acc,
    output logic [ACC_W+RUN_W-1:0] acc_sum,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   done_q, done_d;
    logic [RUN_W-1:0]       num_runs_q, num_runs_d;
    logic [RUN_W-1:0]       run_count_q, run_count_d;
    logic [ACC_W-1:0]       last_acc_q, last_acc_d;
    logic [ACC_W-1:0]       min_acc_q, min_acc_d;
    logic [ACC_W-1:0]       max_acc_q, max_acc_d;
    logic [ACC_W+RUN_W-1:0] acc_sum_q, acc_sum_d;
    logic [RUN_W-1:0]       run_inc;
    logic                   capture;

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
`endif

    // Only a rising edge of mlp_done seen in WAIT counts as a finished run.
    assign capture = (state_q == S_WAIT) && mlp_done && !done_q;
    assign run_inc = run_count_q + RUN_W'(1);

    always_comb begin
        state_d     = state_q;
        done_d      = mlp_done;
        num_runs_d  = num_runs_q;
        run_count_d = run_count_q;
        last_acc_d  = last_acc_q;
        min_acc_d   = min_acc_q;
        max_acc_d   = max_acc_q;
        acc_sum_d   = acc_sum_q;
        mlp_start   = 1'b0;
        all_done    = 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    num_runs_d  = num_runs;
                    run_count_d = '0;
                    last_acc_d  = '0;
                    min_acc_d   = '0;
                    max_acc_d   = '0;
                    acc_sum_d   = '0;
`ifdef MLP_SEQ_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    state_d     = (num_runs != '0) ? S_START : S_DONE;
                end
            end
            S_START: begin
                mlp_start = 1'b1;
                state_d   = S_WAIT;
`ifdef MLP_SEQ_TIMEOUT_EN
                wdog_d    = '0;
`endif
            end
            S_WAIT: begin
                if (capture) begin
                    last_acc_d  = mlp_accuracy;
                    acc_sum_d   = acc_sum_q + {{RUN_W{1'b0}}, mlp_accuracy};
                    run_count_d = run_inc;
                    if (run_count_q == '0) begin
                        min_acc_d = mlp_accuracy;
                        max_acc_d = mlp_accuracy;
                    end else begin
                        if (mlp_accuracy < min_acc_q) min_acc_d = mlp_accuracy;
                        if (mlp_accuracy > max_acc_q) max_acc_d = mlp_accuracy;
                    end
                    state_d = (run_inc == num_runs_q) ? S_DONE : S_START;
                end
`ifdef MLP_SEQ_TIMEOUT_EN
                else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end
            S_DONE: begin
                all_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            num_runs_q  <= '0;
            run_count_q <= '0;
            last_acc_q  <= '0;
            min_acc_q   <= '0;
            max_acc_q   <= '0;
            acc_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            num_runs_q  <= num_runs_d;
            run_count_q <= run_count_d;
            last_acc_q  <= last_acc_d;
            min_acc_q   <= min_acc_d;
            max_acc_q   <= max_acc_d;
            acc_sum_q   <= acc_sum_d;
        end
    end

`ifdef MLP_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign run_count = run_count_q;
    assign last_acc  = last_acc_q;
    assign min_acc   = min_acc_q;
    assign max_acc   = max_acc_q;
    assign acc_sum   = acc_sum_q;

endmodule

// File: tb/tb_mlp_run_sequencer.sv
// tb/tb_mlp_run_sequencer.sv - randomized self-checking bench for mlp_run_sequencer
// Timeout scenario follows MLP_SEQ_TIMEOUT_EN when defined.
module tb_mlp_run_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  num_runs;
    logic        mlp_done;
    logic [9:0]  mlp_accuracy;
    logic        mlp_start;
    logic        busy;
    logic        all_done;
    logic [7:0]  run_count;
    logic [9:0]  last_acc;
    logic [9:0]  min_acc;
    logic [9:0]  max_acc;
    logic [17:0] acc_sum;
    logic        timeout;

    int vecs = 0;
    int errs = 0;
    int starts_seen = 0;
    int alldone_seen = 0;
    int bs, bd;
    int acc_q[$];

    mlp_run_sequencer #(.ACC_W(10), .RUN_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .go(go), .num_runs(num_runs),
        .mlp_done(mlp_done), .mlp_accuracy(mlp_accuracy),
        .mlp_start(mlp_start), .busy(busy), .all_done(all_done),
        .run_count(run_count), .last_acc(last_acc), .min_acc(min_acc),
        .max_acc(max_acc), .acc_sum(acc_sum), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mlp_start) starts_seen++;
        if (all_done) alldone_seen++;
    end

    // Plays the MLP for one batch: answers each mlp_start with a done after a latency.
    task automatic run_batch(input int n, input int acc_tab[$], input int lat_fix,
                             input int hold_max, input bit noise);
        int wc, lat, a, h;
        bs = starts_seen;
        bd = alldone_seen;
        acc_q.delete();
        @(posedge clk); #1;
        go = 1'b1; num_runs = 8'(n);
        @(posedge clk); #1;
        go = 1'b0; num_runs = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            wc = 0;
            do begin @(posedge clk); wc++; end while ((starts_seen - bs) <= i && wc < 300);
            if ((starts_seen - bs) <= i) begin
                vecs++; errs++;
                $display("FAIL start_wait run %0d: saw %0d starts, required %0d", i, starts_seen - bs, i + 1);
                return;
            end
            #1;
            lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 6));
            repeat (lat) begin @(posedge clk); #1; end
            if (noise) begin
                go = 1'b1; num_runs = 8'($urandom_range(1, 255));
                @(posedge clk); #1;
                go = 1'b0;
            end
            a = (acc_tab.size() > 0) ? acc_tab[i] : int'($urandom_range(0, 1023));
            mlp_accuracy = 10'(a);
            mlp_done = 1'b1;
            acc_q.push_back(a);
            h = int'($urandom_range(1, hold_max));
            repeat (h) begin @(posedge clk); #1; end
            mlp_done = 1'b0;
            mlp_accuracy = 10'($urandom);
        end
        wc = 0;
        while ((alldone_seen - bd) < 1 && wc < 300) begin @(posedge clk); wc++; end
        if ((alldone_seen - bd) < 1) begin
            vecs++; errs++;
            $display("FAIL all_done_wait: saw %0d pulses, required 1", alldone_seen - bd);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; num_runs = 8'd0; mlp_done = 1'b0; mlp_accuracy = 10'd0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy, mlp_start, all_done, timeout} !== 4'b0) begin
            errs++; $display("FAIL reset_flags: got %b, required 0000", {busy, mlp_start, all_done, timeout});
        end
        vecs++;
        if ({run_count, last_acc, min_acc, max_acc, acc_sum} !== 56'b0) begin
            errs++; $display("FAIL reset_stats: got %h, required 0", {run_count, last_acc, min_acc, max_acc, acc_sum});
        end
    endtask

    task automatic test_batches();
        int n, hold;
        bit noise;
        int tab[$];
        logic [7:0]  exp_cnt;
        logic [9:0]  exp_last, exp_min, exp_max;
        logic [17:0] exp_sum;
        for (int s = 0; s < 9; s++) begin
            tab.delete();
            case (s)
                0: begin
                    n = 3; tab = '{80, 90, 70};
                    run_batch(n, tab, 5, 1, 1'b0);
                end
                1: begin
                    n = 1;
                    run_batch(n, tab, 3, 20, 1'b1);
                end
                8: begin
                    n = 255;
                    for (int k = 0; k < 255; k++) tab.push_back(100);
                    run_batch(n, tab, 0, 1, 1'b0);
                end
                default: begin
                    n = int'($urandom_range(1, 10));
                    hold = int'($urandom_range(1, 4));
                    noise = 1'($urandom);
                    run_batch(n, tab, -1, hold, noise);
                end
            endcase
            exp_cnt = 8'(acc_q.size());
            exp_sum = '0; exp_min = 10'h3ff; exp_max = '0; exp_last = '0;
            foreach (acc_q[k]) begin
                exp_sum = exp_sum + 18'(acc_q[k]);
                if (acc_q[k] < int'(exp_min)) exp_min = 10'(acc_q[k]);
                if (acc_q[k] > int'(exp_max)) exp_max = 10'(acc_q[k]);
                exp_last = 10'(acc_q[k]);
            end
            @(negedge clk);
            vecs++;
            if (starts_seen - bs !== n) begin
                errs++; $display("FAIL batch%0d_starts: got %0d, required %0d", s, starts_seen - bs, n);
            end
            vecs++;
            if (alldone_seen - bd !== 1) begin
                errs++; $display("FAIL batch%0d_all_done: got %0d pulses, required 1", s, alldone_seen - bd);
            end
            vecs++;
            if (run_count !== exp_cnt || last_acc !== exp_last) begin
                errs++; $display("FAIL batch%0d_count_last: got %0d/%0d, required %0d/%0d", s, run_count, last_acc, exp_cnt, exp_last);
            end
            vecs++;
            if (min_acc !== exp_min || max_acc !== exp_max) begin
                errs++; $display("FAIL batch%0d_min_max: got %0d/%0d, required %0d/%0d", s, min_acc, max_acc, exp_min, exp_max);
            end
            vecs++;
            if (acc_sum !== exp_sum) begin
                errs++; $display("FAIL batch%0d_sum: got %0d, required %0d", s, acc_sum, exp_sum);
            end
            vecs++;
            if (busy !== 1'b0 || timeout !== 1'b0) begin
                errs++; $display("FAIL batch%0d_idle: got busy=%b timeout=%b, required 0/0", s, busy, timeout);
            end
        end
    endtask

    task automatic test_zero_runs();
        int hit = 0;
        bs = starts_seen; bd = alldone_seen;
        @(posedge clk); #1;
        go = 1'b1; num_runs = 8'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (all_done && hit == 0) hit = k;
            @(posedge clk); #1;
            go = 1'b0;
        end
        @(negedge clk);
        vecs++;
        if (hit !== 2) begin
            errs++; $display("FAIL zero_runs_all_done_time: got cycle %0d, required 2", hit);
        end
        vecs++;
        if (starts_seen - bs !== 0 || alldone_seen - bd !== 1) begin
            errs++; $display("FAIL zero_runs_pulses: got starts=%0d done=%0d, required 0/1", starts_seen - bs, alldone_seen - bd);
        end
        vecs++;
        if ({run_count, last_acc, min_acc, max_acc, acc_sum} !== 56'b0) begin
            errs++; $display("FAIL zero_runs_stats: got %h, required 0", {run_count, last_acc, min_acc, max_acc, acc_sum});
        end
    endtask

    task automatic test_reset_midbatch();
        int wc;
        bs = starts_seen; bd = alldone_seen;
        @(posedge clk); #1;
        go = 1'b1; num_runs = 8'd4;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wc = 0;
            do begin @(posedge clk); wc++; end while ((starts_seen - bs) <= i && wc < 300);
            #1;
            repeat (2) begin @(posedge clk); #1; end
            if (i == 0) begin
                mlp_accuracy = 10'd55; mlp_done = 1'b1;
                @(posedge clk); #1;
                mlp_done = 1'b0;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy, mlp_start, all_done, timeout} !== 4'b0) begin
            errs++; $display("FAIL midreset_flags: got %b, required 0000", {busy, mlp_start, all_done, timeout});
        end
        vecs++;
        if ({run_count, last_acc, min_acc, max_acc, acc_sum} !== 56'b0) begin
            errs++; $display("FAIL midreset_stats: got %h, required 0", {run_count, last_acc, min_acc, max_acc, acc_sum});
        end
        repeat (5) @(negedge clk);
        vecs++;
        if (starts_seen - bs !== 2 || alldone_seen - bd !== 0) begin
            errs++; $display("FAIL midreset_pulses: got starts=%0d done=%0d, required 2/0", starts_seen - bs, alldone_seen - bd);
        end
    endtask

    task automatic test_timeout();
        int wc;
        int hit = 0;
        bs = starts_seen; bd = alldone_seen;
        @(posedge clk); #1;
        go = 1'b1; num_runs = 8'd2;
        @(posedge clk); #1;
        go = 1'b0;
        wc = 0;
        do begin @(posedge clk); wc++; end while ((starts_seen - bs) < 1 && wc < 300);
`ifdef MLP_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (all_done && hit == 0) hit = k;
        end
        vecs++;
        if (hit !== 17) begin
            errs++; $display("FAIL timeout_time: all_done at cycle %0d, required 17", hit);
        end
        vecs++;
        if (timeout !== 1'b1 || run_count !== 8'd0 || busy !== 1'b0) begin
            errs++; $display("FAIL timeout_state: got timeout=%b run_count=%0d busy=%b, required 1/0/0", timeout, run_count, busy);
        end
        vecs++;
        if (starts_seen - bs !== 1 || alldone_seen - bd !== 1) begin
            errs++; $display("FAIL timeout_pulses: got starts=%0d done=%0d, required 1/1", starts_seen - bs, alldone_seen - bd);
        end
`else
        repeat (1000) @(negedge clk);
        if (all_done) hit = 1;
        vecs++;
        if (busy !== 1'b1 || timeout !== 1'b0 || alldone_seen - bd !== 0) begin
            errs++; $display("FAIL no_timeout: got busy=%b timeout=%b done=%0d, required 1/0/0", busy, timeout, alldone_seen - bd);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            errs++; $display("FAIL timeout_clear: got busy=%b timeout=%b, required 0/0", busy, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_batches();
        test_zero_runs();
        test_reset_midbatch();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
